pwm_decoder: RTL and testbench

//  Servo-PWM receiver/decoder, the receive-side counterpart of the servo PWM generator.

---
 rtl/pwm_decoder.sv | 240 ++++++++++++++++++++++++
 tb/tb_pwm_decoder.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_decoder.sv
`default_nettype none
// ============================================================================
// Module   : pwm_decoder
// Purpose  : Servo-PWM receiver. Measures high time and rising-to-rising
//            period of an incoming pulse train in clk ticks (1 us) and
//            classifies each pulse into the 2-bit direction code used by
//            the servo PWM generator.
// Options  : PWM_DEC_FILT_EN - adds a FILT_LEN-tick stability filter after
//            the synchronizer; pulses or gaps shorter than FILT_LEN ticks
//            are ignored.
// Revision : 1.0 - initial release
// ============================================================================
module pwm_decoder #(
    parameter int CNT_W   = 16,
    parameter int T_STOP  = 1500,
    parameter int T_CCW   = 1520,
    parameter int T_CW    = 1480,
    parameter int TOL     = 5,
    parameter int T_MIN   = 500,
    parameter int T_MAX   = 2500,
    parameter int TIMEOUT = 25000
`ifdef PWM_DEC_FILT_EN
    ,
    parameter int FILT_LEN = 4
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             pwm_in,
    output logic [1:0]       dir_out,
    output logic [CNT_W-1:0] high_us,
    output logic [CNT_W-1:0] period_us,
    output logic             valid,
    output logic             err,
    output logic             loss
);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_high = 2'd1;
    localparam logic [1:0] c_st_low  = 2'd2;

    localparam logic [CNT_W-1:0] c_cnt_max  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_idle_lim = CNT_W'(TIMEOUT - 1);

    // Classification is done one bit wider and signed so |hi - nominal|
    // never wraps around.
    localparam logic signed [CNT_W:0] c_tol  = (CNT_W+1)'(TOL);
    localparam logic signed [CNT_W:0] c_tmin = (CNT_W+1)'(T_MIN);
    localparam logic signed [CNT_W:0] c_tmax = (CNT_W+1)'(T_MAX);
    localparam logic signed [CNT_W:0] c_stop = (CNT_W+1)'(T_STOP);
    localparam logic signed [CNT_W:0] c_ccw  = (CNT_W+1)'(T_CCW);
    localparam logic signed [CNT_W:0] c_cw   = (CNT_W+1)'(T_CW);

    logic             r_sync1;
    logic             r_sync2;
    logic             w_lvl;
    logic             r_lvl_prev;
    logic             w_rise;
    logic             w_fall;
    logic             w_timeout;
    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_hi_cnt;
    logic [CNT_W-1:0] r_per_cnt;
    logic [CNT_W-1:0] r_idle_cnt;
    logic [CNT_W-1:0] r_hi_lat;
    logic signed [CNT_W:0] w_hi_s;
    logic             w_range_err;
    logic [1:0]       w_class;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == c_cnt_max) ? v : v + c_cnt_one;
    endfunction

    function automatic logic in_win(input logic signed [CNT_W:0] hi,
                                    input logic signed [CNT_W:0] nom);
        logic signed [CNT_W:0] d;
        d = hi - nom;
        return (d >= -c_tol) && (d <= c_tol);
    endfunction

    // Two-flop synchronizer for the asynchronous PWM input
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= pwm_in;
            r_sync2 <= r_sync1;
        end
    end

`ifdef PWM_DEC_FILT_EN
    localparam int c_fw = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN);
    localparam logic [c_fw-1:0] c_filt_last = c_fw'(FILT_LEN - 1);

    logic            r_filt;
    logic [c_fw-1:0] r_fcnt;

    // Stability filter: the level flips only after FILT_LEN consecutive
    // samples disagree with it, delaying both edges by the same amount
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_filt <= 1'b0;
            r_fcnt <= '0;
        end else if (r_sync2 == r_filt) begin
            r_fcnt <= '0;
        end else if (r_fcnt == c_filt_last) begin
            r_filt <= r_sync2;
            r_fcnt <= '0;
        end else begin
            r_fcnt <= r_fcnt + 1'b1;
        end
    end

    assign w_lvl = r_filt;
`else
    assign w_lvl = r_sync2;
`endif

    // Previous level for edge detection; keeps running while disabled so
    // re-enabling mid-pulse never fakes an edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lvl_prev <= 1'b0;
        end else begin
            r_lvl_prev <= w_lvl;
        end
    end

    assign w_rise    = w_lvl & ~r_lvl_prev;
    assign w_fall    = ~w_lvl & r_lvl_prev;
    // An edge in the expiry cycle wins over the timeout
    assign w_timeout = (r_idle_cnt >= c_idle_lim) && !w_rise && !w_fall;

    assign w_hi_s      = $signed({1'b0, r_hi_lat});
    assign w_range_err = (w_hi_s < c_tmin) || (w_hi_s > c_tmax);

    // Map the latched high time onto a direction code, first window wins
    always_comb begin
        w_class = 2'b11;
        if (in_win(w_hi_s, c_stop)) begin
            w_class = 2'b00;
        end else if (in_win(w_hi_s, c_ccw)) begin
            w_class = 2'b01;
        end else if (in_win(w_hi_s, c_cw)) begin
            w_class = 2'b10;
        end
    end

    // Measurement FSM, idle/timeout supervision and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= c_st_idle;
            r_hi_cnt   <= '0;
            r_per_cnt  <= '0;
            r_idle_cnt <= '0;
            r_hi_lat   <= '0;
            dir_out    <= 2'b00;
            high_us    <= '0;
            period_us  <= '0;
            valid      <= 1'b0;
            err        <= 1'b0;
            loss       <= 1'b1;
        end else begin
            valid <= 1'b0;
            if (!en) begin
                r_state    <= c_st_idle;
                r_hi_cnt   <= '0;
                r_per_cnt  <= '0;
                r_idle_cnt <= '0;
                r_hi_lat   <= '0;
            end else begin
                if (w_rise || w_fall) begin
                    r_idle_cnt <= '0;
                end else begin
                    r_idle_cnt <= sat_inc(r_idle_cnt);
                end

                if (w_timeout) begin
                    r_state    <= c_st_idle;
                    r_hi_cnt   <= '0;
                    r_per_cnt  <= '0;
                    r_idle_cnt <= '0;
                    loss       <= 1'b1;
                    dir_out    <= 2'b00;
                end else begin
                    case (r_state)
                        c_st_idle: begin
                            // First rise only arms; the edge tick counts as high
                            if (w_rise) begin
                                r_hi_cnt  <= c_cnt_one;
                                r_per_cnt <= c_cnt_one;
                                r_state   <= c_st_high;
                            end else begin
                                r_hi_cnt  <= '0;
                                r_per_cnt <= '0;
                            end
                        end
                        c_st_high: begin
                            if (w_fall) begin
                                r_hi_lat  <= r_hi_cnt;
                                r_per_cnt <= sat_inc(r_per_cnt);
                                r_state   <= c_st_low;
                            end else begin
                                r_hi_cnt  <= sat_inc(r_hi_cnt);
                                r_per_cnt <= sat_inc(r_per_cnt);
                            end
                        end
                        c_st_low: begin
                            if (w_rise) begin
                                high_us   <= r_hi_lat;
                                period_us <= r_per_cnt;
                                valid     <= 1'b1;
                                loss      <= 1'b0;
                                if (w_range_err) begin
                                    err <= 1'b1;
                                end else begin
                                    err     <= 1'b0;
                                    dir_out <= w_class;
                                end
                                r_hi_cnt  <= c_cnt_one;
                                r_per_cnt <= c_cnt_one;
                                r_state   <= c_st_high;
                            end else begin
                                r_per_cnt <= sat_inc(r_per_cnt);
                            end
                        end
                        default: begin
                            r_state <= c_st_idle;
                        end
                    endcase
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pwm_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_decoder
// Purpose  : Self-checking bench for pwm_decoder. Drives pulse trains as
//            (level, duration) segments and predicts each VALID report from
//            the segment list at pulse level.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pwm_decoder;

    localparam int CNT_W      = 16;
    localparam int T_STOP     = 1500;
    localparam int T_CCW      = 1520;
    localparam int T_CW       = 1480;
    localparam int TOL        = 5;
    localparam int T_MIN      = 500;
    localparam int T_MAX      = 2500;
    localparam int TB_TIMEOUT = 6000;
`ifdef PWM_DEC_FILT_EN
    localparam int FILT_LEN   = 4;
`endif

    typedef struct {
        int hi;
        int per;
        int dir;
        int err;
    } ev_t;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic             pwm_in;
    logic [1:0]       dir_out;
    logic [CNT_W-1:0] high_us;
    logic [CNT_W-1:0] period_us;
    logic             valid;
    logic             err;
    logic             loss;

    int n_total = 0;
    int n_bad   = 0;

    ev_t exp_q[$];
    ev_t got_q[$];
    ev_t mon_ev;

    // pulse-level reference state
    int m_lvl, m_en, m_armed, m_hi, m_lo;
    int m_dir, m_err, m_loss, m_last_hi, m_last_per;

    pwm_decoder #(.TIMEOUT(TB_TIMEOUT)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .pwm_in    (pwm_in),
        .dir_out   (dir_out),
        .high_us   (high_us),
        .period_us (period_us),
        .valid     (valid),
        .err       (err),
        .loss      (loss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // capture every report one step after the active edge
    always @(posedge clk) begin
        #1;
        if (rst_n === 1'b1 && valid === 1'b1) begin
            mon_ev.hi  = int'(high_us);
            mon_ev.per = int'(period_us);
            mon_ev.dir = int'(dir_out);
            mon_ev.err = int'(err);
            got_q.push_back(mon_ev);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    // a completed period: apply the classification rules directly
    task automatic model_close(input int hi, input int per);
        ev_t e;
        e.hi  = hi;
        e.per = per;
        if (hi < T_MIN || hi > T_MAX) begin
            e.err = 1;
            e.dir = m_dir;
        end else begin
            e.err = 0;
            if (iabs(hi - T_STOP) <= TOL)     e.dir = 0;
            else if (iabs(hi - T_CCW) <= TOL) e.dir = 1;
            else if (iabs(hi - T_CW) <= TOL)  e.dir = 2;
            else                              e.dir = 3;
        end
        m_dir      = e.dir;
        m_err      = e.err;
        m_last_hi  = hi;
        m_last_per = per;
        m_loss     = 0;
        exp_q.push_back(e);
    endtask

    task automatic model_reset();
        m_lvl = 0; m_armed = 0; m_hi = 0; m_lo = 0;
        m_dir = 0; m_err = 0; m_loss = 1; m_last_hi = 0; m_last_per = 0;
    endtask

    // drive one segment for n ticks and advance the reference
    task automatic seg(input int lvl, input int n);
        int eff;
        eff = lvl;
`ifdef PWM_DEC_FILT_EN
        if (n < FILT_LEN) eff = m_lvl;
`endif
        if (eff == 1) begin
            if (m_lvl == 0) begin
                if (m_en != 0 && m_armed != 0) model_close(m_hi, m_hi + m_lo);
                if (m_en != 0) m_armed = 1;
                m_hi = n;
                m_lo = 0;
            end else begin
                m_hi += n;
            end
        end else begin
            m_lo += n;
            if (m_en != 0 && m_lo > TB_TIMEOUT) begin
                m_armed = 0;
                m_dir   = 0;
                m_loss  = 1;
            end
        end
        m_lvl = eff;
        @(negedge clk);
        pwm_in = (lvl != 0);
        repeat (n - 1) @(negedge clk);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_dir"},    dir_out,   0);
        check({tag, "_high"},   high_us,   0);
        check({tag, "_period"}, period_us, 0);
        check({tag, "_valid"},  valid,     0);
        check({tag, "_err"},    err,       0);
        check({tag, "_loss"},   loss,      1);
    endtask

    task automatic checkpoint(input string tag);
        ev_t e, g;
        int i;
        i = 0;
        check({tag, "_nvalid"}, got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            check($sformatf("%s_ev%0d_hi",  tag, i), g.hi,  e.hi);
            check($sformatf("%s_ev%0d_per", tag, i), g.per, e.per);
            check($sformatf("%s_ev%0d_dir", tag, i), g.dir, e.dir);
            check($sformatf("%s_ev%0d_err", tag, i), g.err, e.err);
            i++;
        end
        exp_q.delete();
        got_q.delete();
        check({tag, "_dir"},    dir_out,   m_dir);
        check({tag, "_err"},    err,       m_err);
        check({tag, "_loss"},   loss,      m_loss);
        check({tag, "_high"},   high_us,   m_last_hi);
        check({tag, "_period"}, period_us, m_last_per);
    endtask

    initial begin
        int win[5];
        int k, hi;
        win = '{1500, 1505, 1506, 1480, 1475};

        rst_n = 1'b0;
        en    = 1'b0;
        pwm_in = 1'b0;
        m_en  = 0;
        model_reset();
        repeat (5) @(negedge clk);
        check_reset("rst0");
        rst_n = 1'b1;
        en    = 1'b1;
        m_en  = 1;

        // lock: three 1520-tick pulses, first rise only arms
        seg(0, 100);
        repeat (3) begin
            seg(1, 1520);
            seg(0, 2000);
        end
        checkpoint("lock");

        // classification windows and their edges
        foreach (win[i]) begin
            seg(1, win[i]);
            seg(0, 400);
        end
        seg(1, 1500);
        checkpoint("win");

        // out-of-range highs keep the previous direction
        seg(0, 600);
        seg(1, 1520);
        seg(0, 600);
        seg(1, 400);
        seg(0, 600);
        seg(1, 3000);
        seg(0, 600);
        seg(1, 1500);
        checkpoint("range_err");
        seg(0, 600);
        seg(1, 1500);
        checkpoint("range_ok");

        // silent input beyond the timeout
        seg(0, 7000);
        checkpoint("loss");

        // disable mid-pulse, re-enable in the low phase
        seg(1, 1500);
        seg(0, 1000);
        seg(1, 700);
        en = 1'b0; m_en = 0; m_armed = 0;
        seg(1, 800);
        seg(0, 500);
        en = 1'b1; m_en = 1;
        seg(0, 500);
        seg(1, 1480);
        seg(0, 1000);
        seg(1, 1520);
        seg(0, 1000);
        seg(1, 1500);
        checkpoint("enable");

        // randomized pulse widths around the windows and across the range
        for (int i = 0; i < 4; i++) begin
            k = int'($urandom_range(0, 3));
            case (k)
                0:       hi = T_STOP + int'($urandom_range(0, 14)) - 7;
                1:       hi = T_CCW  + int'($urandom_range(0, 14)) - 7;
                2:       hi = T_CW   + int'($urandom_range(0, 14)) - 7;
                default: hi = int'($urandom_range(300, 2800));
            endcase
            seg(0, int'($urandom_range(300, 800)));
            seg(1, hi);
        end
        seg(0, 500);
        seg(1, 1500);
        checkpoint("rand");

        // reset in the middle of a pulse
        seg(0, 500);
        seg(1, 1520);
        seg(0, 500);
        seg(1, 700);
        rst_n = 1'b0;
        model_reset();
        seg(0, 20);
        check_reset("rst_mid");
        rst_n = 1'b1;
        seg(0, 300);
        seg(1, 1500);
        seg(0, 800);
        seg(1, 1520);
        seg(0, 800);
        seg(1, 1480);
        checkpoint("after_rst");

        // 2-tick glitch inside the low phase of a 1480 stream
        seg(0, 700);
        seg(1, 1480);
        seg(0, 700);
        seg(1, 2);
        seg(0, 700);
        seg(1, 1480);
        seg(0, 1400);
        seg(1, 1480);
        checkpoint("glitch");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
